fc2_sequencer: RTL and testbench

Control unit that sequences one inference pass of the 10-output fully-connected layer datapath. The layer has 84 inputs and shares its weight and bias memories with the RISC-V loader.
- Takes memory address ownership from the RISC-V loader.
- Streams weight addresses and IFM selects, inserts the bias accumulate and waits for the MAC pipeline to drain.
- Hands results to the next layer.
- Sits between the previous layer's start/end handshake and the FC datapath. Replaces hard-wired sequencing with a latency-parameterised FSM.

---
 rtl/fc_ctrl_pkg.sv | 37 +++
 rtl/fc2_sequencer_if.sv | 36 +++
 rtl/fc_ctrl_delay.sv | 18 +
 rtl/fc2_sequencer.sv | 146 ++++++++++++++
 tb/tb_fc2_sequencer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fc_ctrl_pkg.sv
// Shared definitions for the FC layer control path: state encoding,
// default layer geometry and a width helper used by the sequencer and datapath.
package fc_ctrl_pkg;

  localparam int DEF_IFM_DEPTH     = 84;
  localparam int DEF_ARITH_LATENCY = 3;
  localparam int DEF_NUMBER_OF_WM  = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT_RD = 3'd2,
    BIAS    = 3'd3,
    DRAIN   = 3'd4,
    WRITE   = 3'd5
  } state_t;

  // Registered control outputs, kept together so the whole set can be
  // computed in one place and cleared with a single assignment.
  typedef struct packed {
    logic wm_addr_sel;
    logic wm_enable_read;
    logic end_to_previous;
    logic bias_sel;
    logic fc_output_ready;
    logic enable_write_next;
    logic output_ready;
    logic busy;
  } ctrl_out_t;

  // Counter width for a count range of n values; never narrower than one bit
  // so a single-word layer still has a usable address port.
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fc2_sequencer_if.sv
// Handshake and memory-control bundle between the FC sequencer and the
// datapath / neighbouring layers.
interface fc2_sequencer_if #(
  parameter int ADDRESS_SIZE_WM = 7
);

  logic                       start_from_previous;
  logic                       end_to_previous;
  logic                       wm_addr_sel;
  logic                       wm_enable_read;
  logic [ADDRESS_SIZE_WM-1:0] wm_address_read_current;
  logic [ADDRESS_SIZE_WM-1:0] sel_ifm;
  logic                       enable_read_current;
  logic                       bias_sel;
  logic                       fc_output_ready;
  logic                       enable_write_next;
  logic                       output_ready;
  logic                       busy;

  // Sequencer side.
  modport master (
    input  start_from_previous,
    output end_to_previous, wm_addr_sel, wm_enable_read,
           wm_address_read_current, sel_ifm, enable_read_current,
           bias_sel, fc_output_ready, enable_write_next, output_ready, busy
  );

  // Datapath / neighbouring-layer side.
  modport slave (
    output start_from_previous,
    input  end_to_previous, wm_addr_sel, wm_enable_read,
           wm_address_read_current, sel_ifm, enable_read_current,
           bias_sel, fc_output_ready, enable_write_next, output_ready, busy
  );

endinterface

// File: rtl/fc_ctrl_delay.sv
// One-cycle register stage that re-aligns control with weight-memory read
// data. Kept separate so a deeper memory only needs more stages here.
module fc_ctrl_delay #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Delay register, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/fc2_sequencer.sv
// Sequencer for one inference pass of the fully-connected layer: claims the
// weight-memory address, streams IFM words, adds the bias, waits for the MAC
// pipeline to drain and strobes the results to the next layer.
module fc2_sequencer
  import fc_ctrl_pkg::*;
#(
  parameter int IFM_DEPTH     = DEF_IFM_DEPTH,
  parameter int ARITH_LATENCY = DEF_ARITH_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  fc2_sequencer_if.master   bus
);

  localparam int ADDRESS_SIZE_WM = addr_width(IFM_DEPTH);
  localparam int DRAIN_W         = addr_width(ARITH_LATENCY);

  localparam logic [ADDRESS_SIZE_WM-1:0] LAST_ADDR  = ADDRESS_SIZE_WM'(IFM_DEPTH - 1);
  localparam logic [DRAIN_W-1:0]         LAST_DRAIN =
    DRAIN_W'((ARITH_LATENCY > 0) ? ARITH_LATENCY - 1 : 0);

  state_t                     state_q, state_d;
  logic [ADDRESS_SIZE_WM-1:0] addr_q, addr_d;
  logic [DRAIN_W-1:0]         drain_q, drain_d;
  ctrl_out_t                  out_q, out_d;
  logic [ADDRESS_SIZE_WM:0]   align_d, align_q;

  // State, counters and every output flop; reset abandons any pass in flight.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      drain_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      out_q   <= out_d;
    end
  end

  // Next state plus the output values the next state presents; the outputs
  // are registered, so each branch describes what the next cycle shows.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d             = state_q;
    addr_d              = '0;
    drain_d             = '0;
    out_d               = '0;
    out_d.output_ready  = out_q.output_ready;

    unique case (state_q)
      IDLE: begin
        if (bus.start_from_previous) begin
          state_d               = FETCH;
          out_d.wm_addr_sel     = 1'b1;
          out_d.wm_enable_read  = 1'b1;
          out_d.end_to_previous = (LAST_ADDR == '0);
          out_d.output_ready    = 1'b0;
          out_d.busy            = 1'b1;
        end
      end

      FETCH: begin
        out_d.wm_addr_sel = 1'b1;
        out_d.busy        = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = WAIT_RD;
        end else begin
          addr_d                = addr_q + ADDRESS_SIZE_WM'(1);
          out_d.wm_enable_read  = 1'b1;
          out_d.end_to_previous = (addr_d == LAST_ADDR);
        end
      end

      WAIT_RD: begin
        state_d           = BIAS;
        out_d.wm_addr_sel = 1'b1;
        out_d.busy        = 1'b1;
        out_d.bias_sel    = 1'b1;
      end

      BIAS: begin
        out_d.wm_addr_sel = 1'b1;
        out_d.busy        = 1'b1;
        if (ARITH_LATENCY == 0) begin
          state_d                 = WRITE;
          out_d.fc_output_ready   = 1'b1;
          out_d.enable_write_next = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        out_d.wm_addr_sel = 1'b1;
        out_d.busy        = 1'b1;
        if (drain_q == LAST_DRAIN) begin
          state_d                 = WRITE;
          out_d.fc_output_ready   = 1'b1;
          out_d.enable_write_next = 1'b1;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end

      WRITE: begin
        state_d            = IDLE;
        out_d.output_ready = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // The accumulate enable follows the read enable by the memory latency; the
  // WAIT_RD term adds the bias accumulate, whose select is 0 since the
  // address register is parked at 0 outside FETCH.
  assign align_d = {out_q.wm_enable_read | (state_q == WAIT_RD), addr_q};

  fc_ctrl_delay #(
    .WIDTH (ADDRESS_SIZE_WM + 1)
  ) u_align (
    .clk   (clk),
    .reset (reset),
    .d     (align_d),
    .q     (align_q)
  );

  assign bus.end_to_previous         = out_q.end_to_previous;
  assign bus.wm_addr_sel             = out_q.wm_addr_sel;
  assign bus.wm_enable_read          = out_q.wm_enable_read;
  assign bus.wm_address_read_current = addr_q;
  assign bus.sel_ifm                 = align_q[ADDRESS_SIZE_WM-1:0];
  assign bus.enable_read_current     = align_q[ADDRESS_SIZE_WM];
  assign bus.bias_sel                = out_q.bias_sel;
  assign bus.fc_output_ready         = out_q.fc_output_ready;
  assign bus.enable_write_next       = out_q.enable_write_next;
  assign bus.output_ready            = out_q.output_ready;
  assign bus.busy                    = out_q.busy;

endmodule

// File: tb/tb_fc2_sequencer.sv
// Scoreboard bench for fc2_sequencer in three geometries (84/3, 1/0, 4/2).
// Cycle k is the interval that ends at clock edge k; a start seen at edge a
// produces addresses in cycles a+1.., accumulates from a+2, bias at a+D+2,
// write at a+D+3+L. Expected events are queued when stimulus is issued and
// popped by a per-configuration monitor sampling on the falling edge.
module tb_fc2_sequencer;

  localparam int NCYC = 1500;
  localparam int ASZ  = NCYC + 200;
  localparam int CFG_D [3] = '{84, 1, 4};
  localparam int CFG_L [3] = '{3, 0, 2};

  typedef struct {
    int cyc;
    int val;
    bit b;
  } ev_t;

  bit clk;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int cfg,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d cycle %0d: got %0h expected %0h",
               name, cfg, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int D  = CFG_D[g];
    localparam int L  = CFG_L[g];
    localparam int AW = fc_ctrl_pkg::addr_width(D);

    logic reset;
    bit   done_g;

    fc2_sequencer_if #(.ADDRESS_SIZE_WM(AW)) bus ();

    fc2_sequencer #(
      .IFM_DEPTH     (D),
      .ARITH_LATENCY (L)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    ev_t addr_q [$];
    ev_t end_q  [$];
    ev_t acc_q  [$];
    ev_t wr_q   [$];
    bit  exp_busy [ASZ];
    bit  exp_rdy  [ASZ];
    bit  exp_zero [ASZ];

    // Stimulus and reference model: decides inputs for cycle c and, from the
    // layer's timing rules, queues everything the DUT must show afterwards.
    initial begin
      bit rst_v, st_v;
      for (int c = 0; c < NCYC; c++) begin
        rst_v = !(c < 3 || c == 45 ||
                  (c >= 400 && c < NCYC - 150 && $urandom_range(0, 199) == 0));
        st_v  = (c == 5 || c == 15 || c == 30 || c == 50 || c == 60 ||
                 c == 100 || (c >= 200 && c < 420) ||
                 (c >= 450 && c < NCYC - 150 && $urandom_range(0, 9) == 0));
        reset = rst_v;
        bus.start_from_previous = st_v;

        if (!rst_v) begin
          while (addr_q.size() > 0 && addr_q[$].cyc > c) void'(addr_q.pop_back());
          while (end_q.size()  > 0 && end_q[$].cyc  > c) void'(end_q.pop_back());
          while (acc_q.size()  > 0 && acc_q[$].cyc  > c) void'(acc_q.pop_back());
          while (wr_q.size()   > 0 && wr_q[$].cyc   > c) void'(wr_q.pop_back());
          for (int t = c + 1; t < ASZ; t++) begin
            exp_busy[t] = 1'b0;
            exp_rdy[t]  = 1'b0;
          end
          exp_zero[c + 1] = 1'b1;
        end else if (st_v && !exp_busy[c]) begin
          for (int k = 0; k < D; k++) begin
            addr_q.push_back(ev_t'{c + 1 + k, k, 1'b0});
            acc_q.push_back(ev_t'{c + 2 + k, k, 1'b0});
          end
          acc_q.push_back(ev_t'{c + D + 2, 0, 1'b1});
          end_q.push_back(ev_t'{c + D, 0, 1'b0});
          wr_q.push_back(ev_t'{c + D + 3 + L, 0, 1'b0});
          for (int t = c + 1; t < ASZ; t++) begin
            exp_busy[t] = (t <= c + D + 3 + L);
            exp_rdy[t]  = (t >= c + D + 4 + L);
          end
        end
        @(posedge clk);
        #1;
      end
      check("leftover_addr",  g, addr_q.size(), 0);
      check("leftover_end",   g, end_q.size(),  0);
      check("leftover_acc",   g, acc_q.size(),  0);
      check("leftover_write", g, wr_q.size(),   0);
      done_g = 1'b1;
    end

    // Monitor: compares levels every cycle and pops an expected event
    // whenever one is due, flagging both missing and unexpected strobes.
    always @(negedge clk) begin
      if (cyc >= 1 && cyc < NCYC) begin
        bit e;
        if (exp_zero[cyc])
          check("reset_zero", g,
                32'({bus.wm_address_read_current, bus.sel_ifm,
                     bus.wm_addr_sel, bus.wm_enable_read, bus.end_to_previous,
                     bus.enable_read_current, bus.bias_sel, bus.fc_output_ready,
                     bus.enable_write_next, bus.output_ready, bus.busy}), 0);
        check("busy",         g, bus.busy,         exp_busy[cyc]);
        check("wm_addr_sel",  g, bus.wm_addr_sel,  exp_busy[cyc]);
        check("output_ready", g, bus.output_ready, exp_rdy[cyc]);

        e = (addr_q.size() > 0 && addr_q[0].cyc == cyc);
        check("wm_enable_read", g, bus.wm_enable_read, e);
        if (e) begin
          check("wm_address", g, bus.wm_address_read_current, addr_q[0].val);
          void'(addr_q.pop_front());
        end

        e = (end_q.size() > 0 && end_q[0].cyc == cyc);
        check("end_to_previous", g, bus.end_to_previous, e);
        if (e) void'(end_q.pop_front());

        e = (acc_q.size() > 0 && acc_q[0].cyc == cyc);
        check("enable_read_current", g, bus.enable_read_current, e);
        if (e) begin
          check("sel_ifm",  g, bus.sel_ifm,  acc_q[0].val);
          check("bias_sel", g, bus.bias_sel, acc_q[0].b);
          void'(acc_q.pop_front());
        end else begin
          check("bias_sel_idle", g, bus.bias_sel, 0);
        end

        e = (wr_q.size() > 0 && wr_q[0].cyc == cyc);
        check("fc_output_ready",   g, bus.fc_output_ready,   e);
        check("enable_write_next", g, bus.enable_write_next, e);
        if (e) void'(wr_q.pop_front());
      end
    end
  end

  // Bounded end of run and the summary line.
  initial begin
    repeat (NCYC + 20) @(posedge clk);
    check("stimulus_done", -1,
          {g_cfg[2].done_g, g_cfg[1].done_g, g_cfg[0].done_g}, 3'b111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
